// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter in front of the shared pipeline ALU.
// One request is in flight at a time: IDLE accepts, EXEC drives the ALU for
// one cycle and captures its result, RESP holds the result until consumed.
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e                   state_q, state_d;
  logic                     last_grant_q, last_grant_d;
  logic                     id_q, id_d;
  logic [OPCODE_LENGTH-1:0] op_q, op_d;
  logic [DATA_WIDTH-1:0]    a_q, a_d;
  logic [DATA_WIDTH-1:0]    b_q, b_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;

  logic grant_valid;
  logic grant_id;

  // Round-robin grant; only offered in IDLE and never while flushing.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state_q == StIdle && !flush) begin
      case ({req1_valid, req0_valid})
        2'b01: begin
          grant_valid = 1'b1;
          grant_id    = 1'b0;
        end
        2'b10: begin
          grant_valid = 1'b1;
          grant_id    = 1'b1;
        end
        2'b11: begin
          grant_valid = 1'b1;
          grant_id    = ~last_grant_q;
        end
        default: begin
          grant_valid = 1'b0;
          grant_id    = 1'b0;
        end
      endcase
    end
    req0_ready = grant_valid & ~grant_id;
    req1_ready = grant_valid & grant_id;
  end

  // Next-state and datapath updates; flush overrides every state.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    if (flush) begin
      state_d     = StIdle;
      rsp_valid_d = 1'b0;
      op_d        = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            state_d      = StExec;
            last_grant_d = grant_id;
            id_d         = grant_id;
            op_d         = grant_id ? req1_op : req0_op;
            a_d          = grant_id ? req1_a : req0_a;
            b_d          = grant_id ? req1_b : req0_b;
          end
        end
        StExec: begin
          state_d     = StResp;
          rsp_data_d  = alu_result;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          // Park the ALU on the no-op so it idles with a zero result.
          op_d        = '0;
        end
        StResp: begin
          if (rsp_ready) begin
            state_d     = StIdle;
            rsp_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and datapath registers; reset leaves port 0 first in line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign alu_srca  = a_q;
  assign alu_srcb  = b_q;
  assign alu_op    = op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_alu_share_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned OL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [OL-1:0] req0_op = '0, req1_op = '0;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [DW-1:0] alu_srca, alu_srcb, alu_result, rsp_data;
  logic [OL-1:0] alu_op;
  logic          rsp_valid, rsp_id, busy;
  logic          rsp_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(input logic [OL-1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd11:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd13:   return b;
      default: return '0;
    endcase
  endfunction

  // The ALU itself lives in the bench.
  always_comb alu_result = alu_f(alu_op, alu_srca, alu_srcb);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an op in flight with its age in cycles.
  bit            m_busy, m_last, m_id, m_rid, m_acc0, m_acc1;
  int            m_age;
  logic [OL-1:0] m_op;
  logic [DW-1:0] m_a, m_b, m_res, m_rdata;

  function automatic bit ready0();
    return !m_busy && !flush && req0_valid && (!req1_valid || m_last);
  endfunction
  function automatic bit ready1();
    return !m_busy && !flush && req1_valid && (!req0_valid || !m_last);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_age = 0; m_last = 1; m_id = 0; m_rid = 0; m_acc0 = 0; m_acc1 = 0;
      m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_rdata = '0;
    end else begin
      bit r0, r1;
      r0 = ready0();
      r1 = ready1();
      m_acc0 = 0;
      m_acc1 = 0;
      if (flush) begin
        m_busy = 0;
      end else if (!m_busy) begin
        if (r0 || r1) begin
          m_busy = 1;
          m_age  = 1;
          m_id   = r1;
          m_last = r1;
          m_op   = r1 ? req1_op : req0_op;
          m_a    = r1 ? req1_a : req0_a;
          m_b    = r1 ? req1_b : req0_b;
          m_res  = alu_f(m_op, m_a, m_b);
          m_acc0 = r0;
          m_acc1 = r1;
        end
      end else if (m_age == 1) begin
        m_age   = 2;
        m_rid   = m_id;
        m_rdata = m_res;
      end else if (rsp_ready) begin
        m_busy = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("req0_ready", req0_ready, ready0());
      check("req1_ready", req1_ready, ready1());
      check("alu_op", alu_op, (m_busy && m_age == 1) ? m_op : '0);
      check("alu_srca", alu_srca, m_a);
      check("alu_srcb", alu_srcb, m_b);
      check("rsp_valid", rsp_valid, m_busy && m_age >= 2);
      check("rsp_id", rsp_id, m_rid);
      check("rsp_data", rsp_data, m_rdata);
      check("busy", busy, m_busy);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return DW'($urandom_range(0, 15));
      2:       return '1;
      default: return {1'b1, {(DW-1){1'b0}}};
    endcase
  endfunction

  function automatic logic [OL-1:0] rand_op();
    logic [OL-1:0] ops [6] = '{4'd0, 4'd1, 4'd2, 4'd11, 4'd13, 4'd7};
    return ops[$urandom_range(0, 5)];
  endfunction

  int            g_id [$];
  bit            r_id [$];
  logic [DW-1:0] r_dat [$];
  int            exp_g [3] = '{0, 1, 0};
  logic [DW-1:0] exp_d [3] = '{32'd7, 32'd1, 32'd7};

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_alu_op", alu_op, 0);
    check("reset_rsp_data", rsp_data, 0);

    // Single op: 5 + 7 on port 0.
    step();
    req0_valid = 1; req0_op = 4'd1; req0_a = 32'd5; req0_b = 32'd7; rsp_ready = 1;
    @(negedge clk) check("single_ready", req0_ready, 1);
    step();
    req0_valid = 0;
    @(negedge clk);
    check("single_alu_op", alu_op, 1);
    check("single_srca", alu_srca, 5);
    check("single_srcb", alu_srcb, 7);
    @(negedge clk);
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_id", rsp_id, 0);
    check("single_rsp_data", rsp_data, 12);
    step();
    @(negedge clk) check("single_rsp_done", rsp_valid, 0);

    // Contention from a fresh reset: grants must alternate 0,1,0.
    step();
    reset = 1;
    req0_valid = 1; req0_op = 4'd2;  req0_a = 32'd10;       req0_b = 32'd3;
    req1_valid = 1; req1_op = 4'd11; req1_a = 32'hFFFFFFFF; req1_b = 32'd1;
    rsp_ready = 1;
    #2 reset = 0;
    repeat (10) begin
      @(negedge clk);
      if (req0_ready) g_id.push_back(0);
      if (req1_ready) g_id.push_back(1);
      if (rsp_valid && rsp_ready) begin
        r_id.push_back(rsp_id);
        r_dat.push_back(rsp_data);
      end
    end
    step();
    req0_valid = 0; req1_valid = 0;
    check("cont_grant_count", g_id.size() >= 3, 1);
    check("cont_rsp_count", r_id.size() >= 3, 1);
    for (int i = 0; i < 3; i++) begin
      check("cont_grant", g_id[i], exp_g[i]);
      check("cont_rsp_id", r_id[i], exp_g[i]);
      check("cont_rsp_data", r_dat[i], exp_d[i]);
    end
    repeat (3) step();

    // Backpressure: port 1 LUI held in RESP for 4 cycles while both ports wait.
    rsp_ready = 0;
    req1_valid = 1; req1_op = 4'd13; req1_a = 32'd0; req1_b = 32'h1234;
    @(negedge clk) check("bp_accept", req1_ready, 1);
    step();
    req0_valid = 1; req0_op = 4'd1; req0_a = 32'd1; req0_b = 32'd2;
    step();
    repeat (4) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_id", rsp_id, 1);
      check("bp_rsp_data", rsp_data, 32'h1234);
      check("bp_ready0", req0_ready, 0);
      check("bp_ready1", req1_ready, 0);
    end
    step();
    rsp_ready = 1;
    step();
    @(negedge clk);
    check("bp_released", rsp_valid, 0);
    check("bp_next_ready0", req0_ready, 1);
    check("bp_next_ready1", req1_ready, 0);
    step();
    req0_valid = 0; req1_valid = 0;
    repeat (3) step();

    // Flush during EXEC of a port-1 request, then a port-0 request completes.
    req1_valid = 1; req1_op = 4'd2; req1_a = 32'd9; req1_b = 32'd4;
    @(negedge clk) check("fl_accept1", req1_ready, 1);
    step();
    req1_valid = 0; flush = 1;
    step();
    flush = 0;
    req0_valid = 1; req0_op = 4'd1; req0_a = 32'd20; req0_b = 32'd22;
    @(negedge clk);
    check("fl_busy", busy, 0);
    check("fl_alu_op", alu_op, 0);
    check("fl_rsp_valid", rsp_valid, 0);
    check("fl_ready0", req0_ready, 1);
    step();
    req0_valid = 0;
    @(negedge clk) check("fl_exec_op", alu_op, 1);
    @(negedge clk);
    check("fl_rsp_id", rsp_id, 0);
    check("fl_rsp_data", rsp_data, 42);
    step();

    // Flush and request together in IDLE: nothing accepted.
    flush = 1;
    req0_valid = 1; req0_op = 4'd1; req0_a = 32'd1; req0_b = 32'd1;
    @(negedge clk) check("fa_ready0", req0_ready, 0);
    step();
    flush = 0;
    @(negedge clk);
    check("fa_busy", busy, 0);
    check("fa_ready_after", req0_ready, 1);
    step();
    req0_valid = 0;
    repeat (3) step();

    // Random traffic honouring the hold-until-ready rule.
    repeat (3000) begin
      if (!req0_valid || m_acc0) begin
        req0_valid = $urandom_range(0, 1);
        req0_op = rand_op(); req0_a = rand_data(); req0_b = rand_data();
      end
      if (!req1_valid || m_acc1) begin
        req1_valid = $urandom_range(0, 1);
        req1_op = rand_op(); req1_a = rand_data(); req1_b = rand_data();
      end
      rsp_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 19) == 0);
      step();
    end
    req0_valid = 0; req1_valid = 0; flush = 0; rsp_ready = 1;
    repeat (4) step();

    // Asynchronous reset in RESP clears outputs before any clock edge.
    rsp_ready = 0;
    req0_valid = 1; req0_op = 4'd1; req0_a = 32'd3; req0_b = 32'd4;
    step();
    req0_valid = 0;
    step();
    @(negedge clk) check("ar_in_resp", rsp_valid, 1);
    #2 reset = 1;
    #1;
    check("ar_rsp_valid", rsp_valid, 0);
    check("ar_busy", busy, 0);
    step();
    reset = 0;
    @(negedge clk) check("ar_after", rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single pipeline ALU between two requesters: port 0 is the EX stage, port 1 is an auxiliary unit such as a branch/address helper.
- Accepts one request at a time over valid/ready handshakes, using round-robin arbitration.
- Drives the registered operands and opcode into the ALU for one cycle, then captures ALUResult.
- Returns the result with a requester ID over a valid/ready response channel.

Parameters:
- DATA_WIDTH, 32, width of operands and result.
- OPCODE_LENGTH, 4, width of the ALU Operation code (1=ADD, 2=SUB, 11=SLT, 13=LUI, 0=no-op, result 0).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort of any in-flight operation.
- req0_valid  input  1  port 0 request valid.
- req0_ready  output  1  port 0 request accepted this cycle.
- req0_op  input  OPCODE_LENGTH  port 0 opcode.
- req0_a  input  DATA_WIDTH  port 0 operand A.
- req0_b  input  DATA_WIDTH  port 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as port 0, for port 1.
- alu_srca  output  DATA_WIDTH  to ALU SrcA.
- alu_srcb  output  DATA_WIDTH  to ALU SrcB.
- alu_op  output  OPCODE_LENGTH  to ALU Operation.
- alu_result  input  DATA_WIDTH  from ALU ALUResult (combinational).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  1  requester that issued the response.
- rsp_data  output  DATA_WIDTH  captured ALU result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-high. Reset forces:
  - state=IDLE, last_grant=1 (so port 0 wins first);
  - operand and op registers to 0 (alu_op=0);
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - Reset mid-operation discards everything immediately, with no response.
- FSM states:
  - IDLE → EXEC on an accepted request.
  - EXEC → RESP unconditionally after one cycle.
  - RESP → IDLE when rsp_ready=1.
- req_ready:
  - Combinational.
  - High only in IDLE with flush=0, and only for the granted port.
  - At most one ready per cycle.
- Arbitration in IDLE:
  - If only one port is valid, that port is granted.
  - If both are valid, the port ≠ last_grant is granted.
  - last_grant updates on every accept.
- Accept (valid&ready at edge N):
  - Latch op/a/b into the alu_op/alu_srca/alu_srcb registers and the port index into the id register.
  - The ALU sees the operands throughout cycle N+1 (EXEC).
- EXEC (edge N+1): rsp_data←alu_result, rsp_id←id, rsp_valid←1. rsp_valid is first high in cycle N+2, so latency is 2 cycles from accept.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1.
  - At that edge rsp_valid←0 and state→IDLE.
  - alu_op←0 when leaving EXEC, so the ALU idles with result 0.
  - No new request is accepted in RESP: the earliest next accept is the cycle after the response handshake, giving a throughput of 1 op per 3 cycles with no backpressure.
- flush:
  - flush=1 at an edge forces state→IDLE, rsp_valid←0, alu_op←0.
  - No accept occurs in a cycle with flush=1.
  - last_grant is unchanged by flush.
- Request holding: a requester must hold valid/op/a/b stable until ready. The arbiter never drops an accepted request except on flush or reset.
- Width: data passes through unmodified; no extension or truncation is performed by the arbiter.

Test Plan:
- Single op:
  - After reset, port 0 requests op=1, a=5, b=7, with rsp_ready=1.
  - Expect req0_ready=1 in the same cycle.
  - Expect alu_op=1, alu_srca=5, alu_srcb=7 the next cycle.
  - Expect rsp_valid=1, rsp_id=0, rsp_data=12 two cycles after accept.
- Contention:
  - Both ports hold valid continuously: port 0 op=2, a=10, b=3; port 1 op=11, a=0xFFFFFFFF, b=1.
  - Expect grants alternating 0,1,0.
  - Expect responses (id0, 7), (id1, 1), (id0, 7).
- Backpressure:
  - Hold rsp_ready=0 for 4 cycles in RESP.
  - Expect rsp_valid/rsp_id/rsp_data stable and both req_ready=0.
  - Raise rsp_ready; expect rsp_valid=0 next cycle and a new accept possible in the following cycle.
- Flush in EXEC:
  - Pulse flush during EXEC of a port-1 request.
  - Expect no response, busy=0, alu_op=0.
  - A port-0 request accepted in the next cycle returns normally.
- Flush and accept together: flush=1 with req0_valid=1 in IDLE → req0_ready=0 and no state change.
- Async reset mid-RESP: assert reset between clock edges → rsp_valid=0 and busy=0 immediately, before the next edge.
